mem_stage: RTL and testbench

Memory-access stage of the five-stage RISC-V pipeline, directly downstream of the execute stage and upstream of write-back. It registers the execute-to-memory bus and performs word stores to data memory through a request/acknowledge handshake, stalling until each store is acknowledged. It executes CSR read-modify-write commands and selects the write-back value. It also drives the memory-stage forwarding bus to decode.

---
 rtl/mem_stage_pkg.sv | 39 +++
 rtl/mem_store_ctrl.sv | 48 ++++
 rtl/mem_stage.sv | 100 ++++++++++
 tb/tb_mem_stage.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared constants and types for the memory-access stage: bus widths,
// write-back and CSR command encodings, and the store FSM state type.
package mem_stage_pkg;

  localparam int EXE_MEM_W = 187;
  localparam int MEM_WB_W  = 70;
  localparam int FWD_W     = 38;

  localparam logic [2:0] WB_ALU = 3'd0;
  localparam logic [2:0] WB_MEM = 3'd1;
  localparam logic [2:0] WB_PC4 = 3'd2;
  localparam logic [2:0] WB_CSR = 3'd3;

  localparam logic [3:0] CSR_W = 4'b0001;
  localparam logic [3:0] CSR_S = 4'b0010;
  localparam logic [3:0] CSR_C = 4'b0100;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_WAIT_DONE = 1'b1
  } store_state_e;

  // Field order matches the execute-to-memory bus, MSB first.
  typedef struct packed {
    logic [31:0] alu_result;
    logic [4:0]  rd;
    logic        rd_wen;
    logic        mem_we;
    logic        mem_re;
    logic [2:0]  wb_sel;
    logic [31:0] pc;
    logic [31:0] wb_data;
    logic [3:0]  csr_cmd;
    logic [11:0] csr_addr;
    logic [31:0] op1_data;
    logic [31:0] mem_rd_data;
  } exe_mem_bus_t;

endpackage

// File: rtl/mem_store_ctrl.sv
// Store handshake controller: issues one write request per store and holds
// the stage until the store has been acknowledged and the instruction leaves.
//   state        | meaning
//   ST_IDLE      | no store acknowledged yet for the instruction in the stage
//   ST_WAIT_DONE | store acknowledged, waiting for write-back to take it
module mem_store_ctrl
  import mem_stage_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic ms_valid,
  input  logic mem_we,
  input  logic ws_allowin,
  input  logic dmem_wack,
  output logic dmem_wreq,
  output logic ms_ready_go,
  output logic ms_leave
);

  store_state_e state_q, state_d;
  logic         is_store;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (dmem_wreq && dmem_wack && !ms_leave) state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (ms_leave) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Request depends only on registered state, never on dmem_wack.
  always_comb begin
    is_store    = ms_valid && mem_we;
    dmem_wreq   = is_store && (state_q == ST_IDLE);
    ms_ready_go = !is_store || dmem_wack || (state_q == ST_WAIT_DONE);
    ms_leave    = ms_valid && ms_ready_go && ws_allowin;
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers the execute bus, performs stores,
// executes CSR read-modify-write commands and selects the write-back value.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [EXE_MEM_W-1:0] exe_mem_bus_in,
  input  logic                 es_to_ms_valid,
  output logic                 ms_allowin,
  input  logic                 ws_allowin,
  output logic                 ms_to_ws_valid,
  output logic [MEM_WB_W-1:0]  mem_wb_bus_out,
  output logic [FWD_W-1:0]     mem_id_data_bus,
  output logic                 dmem_wreq,
  output logic [31:0]          dmem_waddr,
  output logic [31:0]          dmem_wdata,
  input  logic                 dmem_wack,
  output logic [11:0]          csr_raddr,
  input  logic [31:0]          csr_rdata,
  output logic                 csr_we,
  output logic [11:0]          csr_waddr,
  output logic [31:0]          csr_wdata
);

  logic         ms_valid_q, ms_valid_d;
  exe_mem_bus_t bus_q, bus_d;
  logic         ms_ready_go;
  logic         ms_leave;
  logic         csr_cmd_ok;
  logic [31:0]  wb_value;
  logic         unused_mem_re;

  assign unused_mem_re = bus_q.mem_re;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ms_valid_q <= 1'b0;
      bus_q      <= '0;
    end else begin
      ms_valid_q <= ms_valid_d;
      bus_q      <= bus_d;
    end
  end

  always_comb begin
    ms_valid_d = ms_valid_q;
    bus_d      = bus_q;
    if (ms_allowin) ms_valid_d = es_to_ms_valid;
    if (es_to_ms_valid && ms_allowin) bus_d = exe_mem_bus_in;
  end

  mem_store_ctrl u_store_ctrl (
    .clk         (clk),
    .rst_n       (rst_n),
    .ms_valid    (ms_valid_q),
    .mem_we      (bus_q.mem_we),
    .ws_allowin  (ws_allowin),
    .dmem_wack   (dmem_wack),
    .dmem_wreq   (dmem_wreq),
    .ms_ready_go (ms_ready_go),
    .ms_leave    (ms_leave)
  );

  assign ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid_q && ms_ready_go;

  // csr_rdata is the pre-write value since the write lands at the clock edge.
  always_comb begin
    wb_value = 32'd0;
    case (bus_q.wb_sel)
      WB_ALU:  wb_value = bus_q.alu_result;
      WB_MEM:  wb_value = bus_q.mem_rd_data;
      WB_PC4:  wb_value = bus_q.pc + 32'd4;
      WB_CSR:  wb_value = csr_rdata;
      default: wb_value = 32'd0;
    endcase
  end

  always_comb begin
    csr_cmd_ok = 1'b1;
    csr_wdata  = 32'd0;
    case (bus_q.csr_cmd)
      CSR_W:   csr_wdata = bus_q.op1_data;
      CSR_S:   csr_wdata = csr_rdata | bus_q.op1_data;
      CSR_C:   csr_wdata = csr_rdata & ~bus_q.op1_data;
      default: csr_cmd_ok = 1'b0;
    endcase
  end

  assign csr_we     = ms_leave && csr_cmd_ok;
  assign csr_raddr  = bus_q.csr_addr;
  assign csr_waddr  = bus_q.csr_addr;
  assign dmem_waddr = bus_q.alu_result;
  assign dmem_wdata = bus_q.wb_data;

  assign mem_wb_bus_out  = {wb_value, bus_q.rd, bus_q.rd_wen, bus_q.pc};
  assign mem_id_data_bus = {wb_value, bus_q.rd_wen & ms_valid_q, bus_q.rd};

endmodule

// File: tb/tb_mem_stage.sv
// Randomized and directed bench for mem_stage: a queue-based scoreboard
// predicts each instruction's write-back, forwarding, store and CSR behaviour.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [186:0] exe_mem_bus_in;
  logic         es_to_ms_valid;
  logic         ms_allowin;
  logic         ws_allowin;
  logic         ms_to_ws_valid;
  logic [69:0]  mem_wb_bus_out;
  logic [37:0]  mem_id_data_bus;
  logic         dmem_wreq;
  logic [31:0]  dmem_waddr;
  logic [31:0]  dmem_wdata;
  logic         dmem_wack;
  logic [11:0]  csr_raddr;
  logic [31:0]  csr_rdata;
  logic         csr_we;
  logic [11:0]  csr_waddr;
  logic [31:0]  csr_wdata;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .exe_mem_bus_in  (exe_mem_bus_in),
    .es_to_ms_valid  (es_to_ms_valid),
    .ms_allowin      (ms_allowin),
    .ws_allowin      (ws_allowin),
    .ms_to_ws_valid  (ms_to_ws_valid),
    .mem_wb_bus_out  (mem_wb_bus_out),
    .mem_id_data_bus (mem_id_data_bus),
    .dmem_wreq       (dmem_wreq),
    .dmem_waddr      (dmem_waddr),
    .dmem_wdata      (dmem_wdata),
    .dmem_wack       (dmem_wack),
    .csr_raddr       (csr_raddr),
    .csr_rdata       (csr_rdata),
    .csr_we          (csr_we),
    .csr_waddr       (csr_waddr),
    .csr_wdata       (csr_wdata)
  );

  typedef struct {
    logic [31:0] alu, pc, wdat, op1, mrd;
    logic [4:0]  rd;
    logic        rd_wen, we, re;
    logic [2:0]  sel;
    logic [3:0]  cmd;
    logic [11:0] caddr;
    logic        acked;
  } tx_t;

  // CSR file seen by the DUT (8 entries, indexed by low address bits).
  logic [31:0] csr_file [8];
  logic        pre_we;
  logic [2:0]  pre_idx;
  logic [31:0] pre_val;
  assign csr_rdata = csr_file[csr_raddr[2:0]];
  always @(posedge clk) begin
    if (pre_we) csr_file[pre_idx] <= pre_val;
    else if (csr_we) csr_file[csr_waddr[2:0]] <= csr_wdata;
  end

  logic [31:0] csr_ref [8];
  tx_t q[$];
  tx_t cur;
  int  n_vec = 0, n_fail = 0, n_wreq = 0, n_acks = 0, n_csrwe = 0;

  task automatic chk(input string nm, input logic [69:0] act, input logic [69:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [186:0] pack(input tx_t t);
    return {t.alu, t.rd, t.rd_wen, t.we, t.re, t.sel, t.pc, t.wdat,
            t.cmd, t.caddr, t.op1, t.mrd};
  endfunction

  function automatic logic [31:0] exp_wb(input tx_t t, input logic [31:0] csr_now);
    case (t.sel)
      3'd0:    return t.alu;
      3'd1:    return t.mrd;
      3'd2:    return t.pc + 32'd4;
      3'd3:    return csr_now;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic cmd_valid(input logic [3:0] c);
    return (c == 4'b0001) || (c == 4'b0010) || (c == 4'b0100);
  endfunction

  function automatic logic [31:0] exp_csr(input tx_t t, input logic [31:0] old);
    if (t.cmd == 4'b0001) return t.op1;
    if (t.cmd == 4'b0010) return old | t.op1;
    return old & ~t.op1;
  endfunction

  function automatic tx_t rand_tx();
    tx_t t;
    int  r;
    t.alu = $urandom; t.pc = $urandom; t.wdat = $urandom;
    t.op1 = $urandom; t.mrd = $urandom;
    t.rd = 5'($urandom_range(0, 31));
    t.rd_wen = 1'($urandom_range(0, 1));
    t.we = ($urandom_range(0, 2) == 0);
    t.re = 1'($urandom_range(0, 1));
    t.sel = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
    r = $urandom_range(0, 4);
    t.cmd = (r == 0) ? 4'b0001 : (r == 1) ? 4'b0010 : (r == 2) ? 4'b0100 : 4'($urandom_range(0, 15));
    t.caddr = 12'($urandom_range(0, 4095));
    t.acked = 1'b0;
    return t;
  endfunction

  function automatic tx_t blank_tx();
    tx_t t;
    t.alu = 0; t.pc = 0; t.wdat = 0; t.op1 = 0; t.mrd = 0; t.rd = 0;
    t.rd_wen = 0; t.we = 0; t.re = 0; t.sel = 0; t.cmd = 0; t.caddr = 0; t.acked = 0;
    return t;
  endfunction

  // Monitor: checks the instruction at the head of the scoreboard each cycle.
  tx_t         mt;
  logic [31:0] mwb, mold;
  logic        mgo, mleave;
  always @(negedge clk) begin
    if (pre_we) csr_ref[pre_idx] = pre_val;
    if (rst_n !== 1'b1) begin
      q.delete();
    end else begin
      if (dmem_wreq) n_wreq++;
      if (csr_we) n_csrwe++;
      if (q.size() == 0) begin
        chk("idle_to_ws_valid", 70'(ms_to_ws_valid), 70'(0));
        chk("idle_wreq", 70'(dmem_wreq), 70'(0));
        chk("idle_csr_we", 70'(csr_we), 70'(0));
        chk("idle_allowin", 70'(ms_allowin), 70'(1));
      end else begin
        mt     = q[0];
        mold   = csr_ref[mt.caddr[2:0]];
        mwb    = exp_wb(mt, mold);
        mgo    = !mt.we || mt.acked || dmem_wack;
        mleave = mgo && ws_allowin;
        chk("wreq", 70'(dmem_wreq), 70'(mt.we && !mt.acked));
        chk("to_ws_valid", 70'(ms_to_ws_valid), 70'(mgo));
        chk("allowin", 70'(ms_allowin), 70'(mleave));
        chk("fwd_bus", 70'(mem_id_data_bus), 70'({mwb, mt.rd_wen, mt.rd}));
        chk("csr_raddr", 70'(csr_raddr), 70'(mt.caddr));
        if (dmem_wreq) begin
          chk("waddr", 70'(dmem_waddr), 70'(mt.alu));
          chk("wdata", 70'(dmem_wdata), 70'(mt.wdat));
          if (dmem_wack) begin
            q[0].acked = 1'b1;
            n_acks++;
          end
        end
        chk("csr_we", 70'(csr_we), 70'(mleave && cmd_valid(mt.cmd)));
        if (mleave && cmd_valid(mt.cmd)) begin
          chk("csr_waddr", 70'(csr_waddr), 70'(mt.caddr));
          chk("csr_wdata", 70'(csr_wdata), 70'(exp_csr(mt, mold)));
          csr_ref[mt.caddr[2:0]] = exp_csr(mt, mold);
        end
        if (mleave) begin
          chk("wb_bus", mem_wb_bus_out, {mwb, mt.rd, mt.rd_wen, mt.pc});
          void'(q.pop_front());
        end
      end
    end
  end

  // Scoreboard feed: record each instruction the stage accepts.
  always @(negedge clk) begin
    #1;
    if (rst_n === 1'b1 && es_to_ms_valid && ms_allowin) begin
      cur.acked = 1'b0;
      q.push_back(cur);
    end
  end

  task automatic drive(input logic v, input tx_t t, input logic ws, input logic ack);
    @(posedge clk);
    #1;
    es_to_ms_valid = v;
    cur            = t;
    exe_mem_bus_in = pack(t);
    ws_allowin     = ws;
    dmem_wack      = ack;
  endtask

  task automatic preset(input int idx, input logic [31:0] val);
    @(posedge clk);
    #1;
    pre_we = 1'b1; pre_idx = 3'(idx); pre_val = val;
    @(posedge clk);
    #1;
    pre_we = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wreq"}, 70'(dmem_wreq), 70'(0));
    chk({tag, "_to_ws_valid"}, 70'(ms_to_ws_valid), 70'(0));
    chk({tag, "_allowin"}, 70'(ms_allowin), 70'(1));
    chk({tag, "_csr_we"}, 70'(csr_we), 70'(0));
    chk({tag, "_wb_bus"}, mem_wb_bus_out, 70'(0));
    chk({tag, "_fwd_bus"}, 70'(mem_id_data_bus), 70'(0));
  endtask

  tx_t idle, t;
  int  base_wreq, base_acks, base_csrwe;

  initial begin
    idle = blank_tx();
    rst_n = 1'b0; es_to_ms_valid = 0; exe_mem_bus_in = '0; ws_allowin = 1;
    dmem_wack = 0; pre_we = 0; pre_idx = 0; pre_val = 0; cur = idle;
    for (int i = 0; i < 8; i++) preset(i, $urandom);
    #2;
    check_reset_outputs("reset");
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (2) drive(0, idle, 1, 0);

    // ALU op, one-cycle latency
    t = idle; t.alu = 32'h1234; t.rd = 5'd5; t.rd_wen = 1;
    base_wreq = n_wreq;
    drive(1, t, 1, 0);
    drive(0, idle, 1, 0);
    @(negedge clk);
    chk("alu_wb_value", 70'(mem_wb_bus_out[69:38]), 70'(32'h1234));
    chk("alu_rd", 70'(mem_wb_bus_out[37:33]), 70'(5));
    chk("alu_valid", 70'(ms_to_ws_valid), 70'(1));
    chk("alu_no_wreq", 70'(n_wreq - base_wreq), 70'(0));

    // store acknowledged on its third request cycle
    t = idle; t.we = 1; t.alu = 32'h80; t.wdat = 32'hDEADBEEF;
    base_wreq = n_wreq; base_acks = n_acks;
    drive(1, t, 1, 0);
    drive(0, idle, 1, 0);
    drive(0, idle, 1, 0);
    drive(0, idle, 1, 1);
    drive(0, idle, 1, 0);
    drive(0, idle, 1, 0);
    chk("store3_wreq_cycles", 70'(n_wreq - base_wreq), 70'(3));
    chk("store3_acks", 70'(n_acks - base_acks), 70'(1));

    // store acked at once while write-back stalls two cycles
    base_wreq = n_wreq; base_acks = n_acks;
    drive(1, t, 1, 0);
    drive(0, idle, 0, 1);
    drive(0, idle, 0, 0);
    drive(0, idle, 1, 0);
    drive(0, idle, 1, 0);
    chk("store_stall_wreq_cycles", 70'(n_wreq - base_wreq), 70'(1));
    chk("store_stall_acks", 70'(n_acks - base_acks), 70'(1));

    // CSRRS with a two-cycle write-back stall
    preset(3, 32'h0F);
    t = idle; t.caddr = 12'h003; t.cmd = 4'b0010; t.op1 = 32'hF0; t.sel = 3'd3;
    base_csrwe = n_csrwe;
    drive(1, t, 0, 0);
    drive(0, idle, 0, 0);
    drive(0, idle, 0, 0);
    drive(0, idle, 1, 0);
    drive(0, idle, 1, 0);
    chk("csrrs_we_pulses", 70'(n_csrwe - base_csrwe), 70'(1));
    chk("csrrs_result", 70'(csr_file[3]), 70'(32'hFF));

    // pc+4 wraps
    t = idle; t.sel = 3'd2; t.pc = 32'hFFFFFFFC;
    drive(1, t, 1, 0);
    drive(0, idle, 1, 0);
    @(negedge clk);
    chk("pc4_wrap", 70'(mem_wb_bus_out[69:38]), 70'(0));

    for (int i = 0; i < 3000; i++)
      drive(1'($urandom_range(0, 1)), rand_tx(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
    repeat (4) drive(0, idle, 1, 1);

    // reset while a store request is pending
    t = idle; t.we = 1; t.alu = 32'h40; t.wdat = 32'h5555AAAA; t.cmd = 4'b0001; t.caddr = 12'h005;
    drive(1, t, 1, 0);
    drive(0, idle, 1, 0);
    #2;
    chk("pre_reset_wreq", 70'(dmem_wreq), 70'(1));
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_pending");
    @(posedge clk); @(posedge clk); #1; rst_n = 1'b1;
    drive(0, idle, 1, 0);

    // reset while waiting in the acknowledged-store state
    drive(1, t, 1, 0);
    drive(0, idle, 0, 1);
    drive(0, idle, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_wait_done");
    @(posedge clk); @(posedge clk); #1; rst_n = 1'b1;
    base_wreq = n_wreq; base_csrwe = n_csrwe;
    repeat (5) drive(0, idle, 1, 1);
    chk("post_reset_wreq", 70'(n_wreq - base_wreq), 70'(0));
    chk("post_reset_csr_we", 70'(n_csrwe - base_csrwe), 70'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
